down_timer: RTL and testbench
=============================

# down_timer

Loadable down-counter / countdown timer: the decrementing counterpart of the team's free-running 4-bit up-counter. It loads a preset, counts down once per unpaused clock, and flags terminal count with a one-cycle `done` pulse. It is instantiated wherever a fixed delay or a periodic tick is needed, for example as a wait-state generator or a rate divider.

## Interface
Parameters:
- `WIDTH`, default 4: counter and preset width in bits (legal range 2..16).

Ports (reset is asynchronous, active-low; clock is `clk`):
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  load `preset` and begin counting; sampled on rising edge.
- `stop`  in  1  abort; return to IDLE, `cnt` frozen at current value.
- `pause`  in  1  hold `cnt` while in RUN.
- `preset`  in  WIDTH  start value, captured only when `start` is accepted.
- `cnt`  out  WIDTH  current count (registered).
- `busy`  out  1  high in RUN (registered / state-decoded).
- `done`  out  1  high for exactly one cycle in DONE state.

## Operation
- Internal registers: `state` (IDLE, RUN, DONE), `cnt`, `pre_q` (latched preset).
- Reset (async, `reset`=0): state=IDLE, `cnt`=0, `pre_q`=0, `busy`=0, `done`=0. Reset deasserted mid-count: the count is lost and the block resumes from IDLE.
- Input priority at each edge: `stop` > `start` > `pause` > normal counting.
- IDLE: `cnt` holds. `start`=1: `pre_q`<=`preset`, `cnt`<=`preset`; next state is RUN when `preset`!=0, DONE when `preset`==0.
- RUN: `stop`=1 → IDLE, `cnt` holds. `start`=1 → restart: reload the new `preset` under the same rules as IDLE. `pause`=1 → hold. Otherwise, if `cnt`==1: `cnt`<=0 and state becomes DONE; else `cnt`<=`cnt`-1.
- DONE: `done`=1, `cnt`=0. Next edge: `stop` → IDLE. `start` → reload as in IDLE. Otherwise → IDLE, or auto-reload (see Configuration).
- `cnt` never decrements below 0; there is no wrap-around. Arithmetic is unsigned WIDTH-bit.
- `busy` = (state==RUN). `done` = (state==DONE). Both are Moore outputs, glitch-free.
- `pause` is ignored in IDLE and DONE.

## Timing
- `start` accepted at edge E0 with `preset`=P≥1 and no pause: `cnt`=P after E0, then P-1 … 1 on successive edges, and 0 after edge E0+P. `done` is high for the cycle between E0+P and E0+P+1.
- Start-to-done latency = P cycles, plus one cycle for each paused cycle.
- P=0: `done` is high in the cycle immediately after E0, and `busy` never asserts.
- `start` in DONE reloads immediately, giving a back-to-back run with no IDLE gap.
- `stop` and `start` asserted on the same edge: `stop` wins and `preset` is not captured.

## Configuration
- Macro `DOWN_TIMER_AUTORELOAD_EN`.
- Defined: DONE with no `stop`/`start` reloads `cnt`<=`pre_q` and enters RUN (or re-enters DONE if `pre_q`==0). The result is a periodic `done` pulse every `pre_q`+1 cycles (every cycle when `pre_q`==0) until `stop` is asserted.
- Undefined: DONE always returns to IDLE, `pre_q` is still latched but unused, and the timer is one-shot.

## Test plan
- Reset: drive `reset`=0 asynchronously mid-RUN with `cnt`=5 → `cnt`=0, `busy`=0, `done`=0 immediately, without waiting for a clock edge. After release the block is in IDLE.
- One-shot: WIDTH=4, `start` with `preset`=4 → `cnt` 4,3,2,1,0 on consecutive edges, `busy` high for 4 cycles, then `done` high for exactly 1 cycle, then IDLE with `cnt`=0.
- Pause and restart: `preset`=6, hold `pause` for 3 cycles at `cnt`=3 → `cnt` stays 3 and `done` arrives at 6+3=9 cycles. Separately, `start` with `preset`=2 at `cnt`=4 → `cnt`=2, then `done` 2 cycles later.
- Boundaries: `preset`=0 → `done` 1 cycle after start, `busy` never high. `preset`=15 → 15 decrements and no wrap below 0.
- Stop priority: `stop`+`start` on the same edge at `cnt`=7 → IDLE, `cnt`=7, new preset ignored, no `done`.
- Auto-reload (macro defined): `preset`=3 → `done` pulses every 4 cycles and `cnt` cycles 3,2,1,0,3…. `stop` → IDLE. With the macro undefined, a single pulse only.

Source files
------------

// File: rtl/down_timer.sv
// down_timer: loadable down-counter / countdown timer.
// Loads a preset on start, decrements once per unpaused clock while in RUN,
// and pulses done for one cycle in DONE when the count reaches zero.
// Optional feature macro: DOWN_TIMER_AUTORELOAD_EN -- when defined, DONE with
// no stop/start reloads the latched preset so the timer runs periodically;
// when undefined the timer is one-shot and returns to IDLE after DONE.
module down_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [WIDTH-1:0] preset,
   output logic [WIDTH-1:0] cnt,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] cnt_nx;
   logic [WIDTH-1:0] pre_q, pre_nx;

   // State, count and latched preset; reset clears everything to an idle zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= ZERO;
         pre_q <= ZERO;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         pre_q <= pre_nx;
      end
   end

   // Next-state / next-count: stop beats start beats pause beats counting.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pre_nx   = pre_q;
      if (stop) begin
         // Abort leaves cnt frozen where it was.
         state_nx = IDLE;
      end else if (start) begin
         // Load (or restart) from any state; a zero preset goes straight to DONE.
         pre_nx   = preset;
         cnt_nx   = preset;
         state_nx = (preset == ZERO) ? DONE : RUN;
      end else begin
         case (state)
            RUN: begin
               if (!pause) begin
                  // Treat a zero count like one so the counter can never wrap.
                  if (cnt == ONE || cnt == ZERO) begin
                     cnt_nx   = ZERO;
                     state_nx = DONE;
                  end else begin
                     cnt_nx = cnt - ONE;
                  end
               end
            end
            DONE: begin
`ifdef DOWN_TIMER_AUTORELOAD_EN
               cnt_nx   = pre_q;
               state_nx = (pre_q == ZERO) ? DONE : RUN;
`else
               state_nx = IDLE;
`endif
            end
            default: ;
         endcase
      end
   end

   // Moore outputs decoded straight from the state register.
   assign busy = (state == RUN);
   assign done = (state == DONE);

   // The count is always zero while done is shown, and busy/done are exclusive.
   a_done_zero : assert property (@(posedge clk) disable iff (!reset) done |-> cnt == ZERO);
   a_excl      : assert property (@(posedge clk) disable iff (!reset) !(busy && done));

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer (WIDTH=4): a behavioural model compared
// every cycle plus directed scenarios with hand-computed literal expectations.
module tb_down_timer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0, stop = 1'b0, pause = 1'b0;
   logic [W-1:0] preset = '0;
   logic [W-1:0] cnt;
   logic         busy, done;

   int checks = 0;
   int errors = 0;

   down_timer #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
      .preset(preset), .cnt(cnt), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: remaining count plus "running"/"finished" flags.
   int m_cnt = 0, m_pre = 0;
   bit m_run = 0, m_fin = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_cnt = 0; m_pre = 0; m_run = 0; m_fin = 0;
      end else if (stop) begin
         m_run = 0; m_fin = 0;
      end else if (start) begin
         m_pre = int'(preset); m_cnt = int'(preset);
         m_run = (m_pre != 0); m_fin = (m_pre == 0);
      end else if (m_run) begin
         if (!pause) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin m_run = 0; m_fin = 1; end
         end
      end else if (m_fin) begin
`ifdef DOWN_TIMER_AUTORELOAD_EN
         m_cnt = m_pre; m_run = (m_pre != 0); m_fin = (m_pre == 0);
`else
         m_fin = 0;
`endif
      end
   end

   // Compare process: outputs checked against the model every falling edge.
   always @(negedge clk) begin
      chk("model_cnt",  int'(cnt),  m_cnt);
      chk("model_busy", int'(busy), int'(m_run));
      chk("model_done", int'(done), int'(m_fin));
   end

   // One clock: inputs take effect at the rising edge, results visible at fall.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic load(input int p);
      start = 1'b1; preset = W'(p);
      tick();
      start = 1'b0;
   endtask

   initial begin
      int n;
      // Reset state
      #2;
      chk("rst_cnt", int'(cnt), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      @(negedge clk); reset = 1'b1;
      tick();
      // Pause is ignored in IDLE
      pause = 1'b1; tick(2); pause = 1'b0;
      chk("idle_pause_cnt", int'(cnt), 0);
      chk("idle_pause_busy", int'(busy), 0);

      // One-shot preset=4: 4,3,2,1 busy then 0 with done, then idle
      load(4);
      chk("os_cnt4", int'(cnt), 4); chk("os_busy", int'(busy), 1);
      tick(); chk("os_cnt3", int'(cnt), 3);
      tick(); chk("os_cnt2", int'(cnt), 2);
      tick(); chk("os_cnt1", int'(cnt), 1); chk("os_busy1", int'(busy), 1);
      tick(); chk("os_cnt0", int'(cnt), 0); chk("os_done", int'(done), 1);
      chk("os_busy0", int'(busy), 0);
      tick();
`ifndef DOWN_TIMER_AUTORELOAD_EN
      chk("os_done_1cyc", int'(done), 0); chk("os_idle_cnt", int'(cnt), 0);
      chk("os_idle_busy", int'(busy), 0);
`endif
      stop = 1'b1; tick(); stop = 1'b0;

      // Pause: preset=6, 3 paused cycles at cnt=3, done 9 cycles after start
      load(6);
      tick(3); chk("pz_cnt3", int'(cnt), 3);
      pause = 1'b1; tick(3); pause = 1'b0;
      chk("pz_hold", int'(cnt), 3); chk("pz_busy", int'(busy), 1);
      n = 6;
      while (!done && n < 30) begin tick(); n++; end
      chk("pz_latency", n, 9);
      stop = 1'b1; tick(); stop = 1'b0;

      // Restart: preset=8, at cnt=4 start preset=2 -> 2, done two cycles later
      load(8);
      tick(4); chk("rs_cnt4", int'(cnt), 4);
      load(2);
      chk("rs_cnt2", int'(cnt), 2);
      tick(); chk("rs_cnt1", int'(cnt), 1); chk("rs_nodone", int'(done), 0);
      tick(); chk("rs_done", int'(done), 1);
      stop = 1'b1; tick(); stop = 1'b0;

      // preset=0: done right after start, busy never high
      load(0);
      chk("z_done", int'(done), 1); chk("z_busy", int'(busy), 0);
      stop = 1'b1; tick(); stop = 1'b0;
      chk("z_after", int'(done), 0);

      // preset=15: 15 decrements, ends at 0 without wrapping
      load(15);
      for (int i = 14; i >= 1; i--) begin
         tick(); chk("mx_cnt", int'(cnt), i);
      end
      tick(); chk("mx_zero", int'(cnt), 0); chk("mx_done", int'(done), 1);
      stop = 1'b1; tick(); stop = 1'b0;
      chk("mx_nowrap", int'(cnt), 0);

      // Stop and start together at cnt=7: stop wins, preset ignored
      load(9);
      tick(2); chk("sp_cnt7", int'(cnt), 7);
      stop = 1'b1; start = 1'b1; preset = 4'd3; tick(); stop = 1'b0; start = 1'b0;
      chk("sp_cnt", int'(cnt), 7); chk("sp_busy", int'(busy), 0);
      tick(2); chk("sp_hold", int'(cnt), 7); chk("sp_nodone", int'(done), 0);

      // Start in DONE: back-to-back reload with no idle gap
      load(1);
      tick(); chk("bb_done", int'(done), 1);
      load(2);
      chk("bb_cnt", int'(cnt), 2); chk("bb_busy", int'(busy), 1);
      tick(2); chk("bb_done2", int'(done), 1);
      stop = 1'b1; tick(); stop = 1'b0;

      // Async reset mid-run at cnt=5: clears without a clock edge
      load(10);
      tick(5); chk("ar_cnt5", int'(cnt), 5);
      #2 reset = 1'b0;
      #1;
      chk("ar_cnt", int'(cnt), 0); chk("ar_busy", int'(busy), 0);
      chk("ar_done", int'(done), 0);
      @(negedge clk); reset = 1'b1;
      tick(2);
      chk("ar_idle_cnt", int'(cnt), 0); chk("ar_idle_busy", int'(busy), 0);

`ifdef DOWN_TIMER_AUTORELOAD_EN
      // Auto-reload preset=3: cnt 3,2,1,0,3... with done every 4 cycles
      load(3);
      for (int k = 0; k < 8; k++) begin
         chk("rl_cnt", int'(cnt), 3 - (k % 4));
         chk("rl_done", int'(done), int'((k % 4) == 3));
         tick();
      end
      stop = 1'b1; tick(); stop = 1'b0;
      chk("rl_stop_busy", int'(busy), 0); chk("rl_stop_done", int'(done), 0);
`else
      // One-shot: a single done pulse, then nothing
      load(3);
      n = 0;
      for (int k = 0; k < 10; k++) begin
         tick(); if (done) n++;
      end
      chk("os_single_pulse", n, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish by 100000");
      $fatal(1);
   end

endmodule
